// File: rtl/circ_conv_pkg.sv
// Shared types and helpers for the circular-convolution sequencer.
package circ_conv_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Width used by the generic saturation helper; wide enough for any
    // practical accumulator.
    localparam int SAT_W = 64;

    // Accumulator width: enough headroom for N summed QLEN-bit products.
    function automatic int acc_w(input int qlen, input int n);
        return qlen + $clog2(n);
    endfunction

    // Clip a sign-extended accumulator into the signed qlen-bit range.
    // The caller keeps the low qlen bits of the result.
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] acc,
                                                    input int                      qlen);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((64'd1 << (qlen - 1)) - 64'd1);
        lo = -hi - 64'sd1;
        if (acc > hi) begin
            return hi;
        end else if (acc < lo) begin
            return lo;
        end
        return acc;
    endfunction

endpackage

// File: rtl/fxp_mult.sv
// Signed fixed-point multiplier: full-width product rescaled by FRAC_SIZE,
// truncated to QLEN bits (overflow wraps).
module fxp_mult #(
    parameter int QLEN      = 16,
    parameter int FRAC_SIZE = 12
) (
    input  logic [QLEN-1:0] a_i,
    input  logic [QLEN-1:0] b_i,
    output logic [QLEN-1:0] p_o
);

    logic signed [2*QLEN-1:0] full;

    // Full 2*QLEN product; operands sign-extended first so the result is exact.
    assign full = (2*QLEN)'($signed(a_i)) * (2*QLEN)'($signed(b_i));

    // Keep bits [QLEN+FRAC_SIZE-1 : FRAC_SIZE] of the product.
    assign p_o = QLEN'(full >>> FRAC_SIZE);

endmodule

// File: rtl/circ_conv_ctrl.sv
// N-point circular convolution sequencer: loads one frame of x/h pairs,
// runs N*N multiply-accumulates through one shared fxp_mult, then streams
// N saturated results.
module circ_conv_ctrl
    import circ_conv_pkg::*;
#(
    parameter int QLEN      = 16,
    parameter int FRAC_SIZE = 12,
    parameter int N         = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [QLEN-1:0] in_x,
    input  logic [QLEN-1:0] in_h,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [QLEN-1:0] out_y,
    output logic            out_last
);

    localparam int CW    = $clog2(N);
    localparam int ACC_W = acc_w(QLEN, N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_t                    state_q, state_d;
    logic [CW-1:0]             i_q, i_d;
    logic [CW-1:0]             k_q, k_d;
    logic [CW-1:0]             j_q, j_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;

    logic [QLEN-1:0]           x_q [N];
    logic [QLEN-1:0]           h_q [N];
    logic [N-1:0]              we;

    logic                      in_hs;
    logic                      out_hs;
    logic [CW-1:0]             h_idx;
    logic [QLEN-1:0]           mul_a;
    logic [QLEN-1:0]           mul_b;
    logic [QLEN-1:0]           prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [SAT_W-1:0]   acc_wide;

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == OUT);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    // k - j in CW bits gives the modular kernel index for free.
    assign h_idx = k_q - j_q;
    assign mul_a = x_q[j_q];
    assign mul_b = h_q[h_idx];

    fxp_mult #(
        .QLEN      (QLEN),
        .FRAC_SIZE (FRAC_SIZE)
    ) u_mult (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    assign prod_ext = {{CW{prod[QLEN-1]}}, prod};

    // One write strobe per register-file entry, decoded from the load index.
    // Writes are suppressed while reset is asserted.
    for (genvar gi = 0; gi < N; gi++) begin : g_we
        assign we[gi] = in_hs && !rst && (i_q == CW'(gi));
    end

    // X/H register files: written during LOAD, never cleared.
    always_ff @(posedge clk) begin
        for (int n = 0; n < N; n++) begin
            if (we[n]) begin
                x_q[n] <= in_x;
                h_q[n] <= in_h;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            i_q     <= '0;
            k_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state logic: load a frame, accumulate one product per cycle,
    // hold each result until the consumer takes it.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        j_d     = j_q;
        acc_d   = acc_q;
        case (state_q)
            LOAD: begin
                if (in_hs) begin
                    i_d = i_q + CW'(1);
                    if (i_q == LAST_IDX) begin
                        state_d = MAC;
                        k_d     = '0;
                        j_d     = '0;
                        acc_d   = '0;
                    end
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                j_d   = j_q + CW'(1);
                if (j_q == LAST_IDX) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_hs) begin
                    if (k_q == LAST_IDX) begin
                        state_d = LOAD;
                        i_d     = '0;
                    end else begin
                        state_d = MAC;
                        k_d     = k_q + CW'(1);
                        j_d     = '0;
                        acc_d   = '0;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign acc_wide = {{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign out_y    = out_valid ? QLEN'(sat(acc_wide, QLEN)) : '0;
    assign out_last = out_valid && (k_q == LAST_IDX);

endmodule

// File: tb/tb_circ_conv_ctrl.sv
// Self-checking bench for circ_conv_ctrl: directed frames, a direct
// arithmetic model of the circular convolution, and a per-cycle checker.
module tb_circ_conv_ctrl;

    localparam int N  = 8;
    localparam int QL = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [QL-1:0]   in_x;
    logic [QL-1:0]   in_h;
    logic            out_valid;
    logic            out_ready;
    logic [QL-1:0]   out_y;
    logic            out_last;

    circ_conv_ctrl #(.QLEN(QL), .FRAC_SIZE(12), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_h      (in_h),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic signed [15:0] fx [N];
    logic signed [15:0] fh [N];

    logic [15:0] exp_y [$];
    logic        exp_last [$];
    int          out_times [$];
    int          out_cnt = 0;
    int          first_in, last_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // y[k] = sum_j trunc16((x[j]*h[(k-j) mod N]) >> 12), then clipped to 16 bits.
    function automatic logic [15:0] model_y(input int k);
        longint s = 0;
        longint p;
        for (int j = 0; j < N; j++) begin
            p = longint'(fx[j]) * longint'(fh[(k - j + N) % N]);
            p = p >>> 12;
            s += longint'(shortint'(p));
        end
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    // Per-cycle checker: result order/values, backpressure stability,
    // and mutual exclusion of in_ready and out_valid.
    logic        prev_stall = 1'b0;
    logic [15:0] prev_y;
    logic        prev_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("bp_valid_held", out_valid, 1);
                check("bp_y_stable", out_y, prev_y);
                check("bp_last_stable", out_last, prev_last);
            end
            if (out_valid) check("in_ready_low_when_out", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_y.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_output: got %h expected none (cycle %0d)", out_y, cyc);
                end else begin
                    check("out_y", out_y, exp_y.pop_front());
                    check("out_last", out_last, exp_last.pop_front());
                end
                out_cnt++;
                out_times.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
            prev_last  = out_last;
        end
    end

    task automatic send_frame();
        int guard;
        for (int k = 0; k < N; k++) begin
            exp_y.push_back(model_y(k));
            exp_last.push_back(k == N - 1);
        end
        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x = fx[n];
            in_h = fh[n];
            guard = 0;
            while (!in_ready && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) begin
                check("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            if (n == 0) first_in = cyc;
            last_in = cyc;
            @(posedge clk);
        end
    endtask

    task automatic wait_out_cnt(input int target);
        int guard = 0;
        while (out_cnt < target && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) check("out_cnt_timeout", out_cnt, target);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_y.size() != 0 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) check("drain_timeout", exp_y.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic set_impulse(input int pos);
        for (int n = 0; n < N; n++) begin
            fx[n] = (n == pos) ? 16'sh1000 : 16'sh0000;
            fh[n] = 16'((n + 1) * 16'h1000);
        end
    endtask

    task automatic set_mixed(input int seed);
        logic [15:0] xa [N] = '{16'h1800, 16'hF000, 16'h0400, 16'h2000,
                                16'hE800, 16'h0100, 16'h7FFF, 16'h8000};
        logic [15:0] ha [N] = '{16'h0800, 16'h1000, 16'hF800, 16'h0200,
                                16'h3000, 16'hC000, 16'h0010, 16'h1234};
        for (int n = 0; n < N; n++) begin
            fx[n] = xa[(n + seed) % N];
            fh[n] = ha[(n + 2 * seed) % N];
        end
    endtask

    initial begin
        int base;
        int ta_last, tb_first, tb_last;
        rst = 1'b1;
        in_valid = 1'b0;
        in_x = '0;
        in_h = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_y", out_y, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Impulse: y = h.
        set_impulse(0);
        check("model_impulse_y0", model_y(0), 16'h1000);
        check("model_impulse_y3", model_y(3), 16'h4000);
        check("model_impulse_y7", model_y(7), 16'h8000);
        send_frame();
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Wrap-around: delta at index 1, y[0] = h[7].
        set_impulse(1);
        check("model_wrap_y0", model_y(0), 16'h8000);
        check("model_wrap_y3", model_y(3), 16'h3000);
        send_frame();
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Positive saturation: 8 * 7.0 = 56.0.
        for (int n = 0; n < N; n++) begin
            fx[n] = 16'sh7000;
            fh[n] = 16'sh1000;
        end
        check("model_sat_pos", model_y(2), 16'h7FFF);
        send_frame();
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Negative saturation: 8 * -7.0 = -56.0.
        for (int n = 0; n < N; n++) fx[n] = 16'sh9000;
        check("model_sat_neg", model_y(5), 16'h8000);
        send_frame();
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        // Backpressure at y[3] for 5 cycles.
        set_mixed(0);
        base = out_cnt;
        send_frame();
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_cnt(base + 3);
        out_ready = 1'b0;
        begin
            int guard = 0;
            while (!out_valid && guard < 100) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check("bp_reach_y3", out_valid, 1);
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        drain();
        check("bp_output_count", out_cnt - base, N);

        // Reset during k=2, j=4, then an impulse frame must be clean.
        set_mixed(3);
        base = out_cnt;
        send_frame();
        @(negedge clk);
        in_valid = 1'b0;
        wait_out_cnt(base + 2);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_y", out_y, 0);
        exp_y.delete();
        exp_last.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_impulse(0);
        base = out_cnt;
        send_frame();
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        check("post_rst_count", out_cnt - base, N);

        // Back-to-back frames with in_valid and out_ready held high.
        out_times.delete();
        set_mixed(5);
        send_frame();
        ta_last = last_in;
        set_impulse(1);
        send_frame();
        tb_first = first_in;
        tb_last = last_in;
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        check("b2b_out_count", out_times.size(), 2 * N);
        if (out_times.size() == 2 * N) begin
            check("b2b_latency_a", out_times[0] - ta_last, N + 1);
            check("b2b_latency_b", out_times[N] - tb_last, N + 1);
            check("b2b_in_ready_after_last", tb_first - out_times[N-1], 1);
            for (int n = 1; n < N; n++) begin
                check("b2b_spacing_a", out_times[n] - out_times[n-1], N + 1);
                check("b2b_spacing_b", out_times[N+n] - out_times[N+n-1], N + 1);
            end
        end
        check("b2b_frame_period", tb_last - ta_last, N + N * (N + 1));

        check("queue_empty", exp_y.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/circ_conv_ctrl.md
# circ_conv_ctrl

Sequencer that computes an N-point circular convolution y[k] = Σ_j x[j]·h[(k−j) mod N] in signed fixed point by time-multiplexing one shared `fxp_mult` instance. It sits between an input sample stream and an output result stream, both valid/ready. It buffers one frame of x/h pairs, runs N×N multiply-accumulate steps, and streams N saturated results.

## Interface
- `QLEN`, default 16: total fixed-point word width.
- `FRAC_SIZE`, default 12: fraction bits, passed to `fxp_mult`.
- `N`, default 8: frame length; must be a power of two and at least 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  `in_x`/`in_h` hold a valid pair.
- `in_ready`  out  1  block accepts a pair this cycle.
- `in_x`  in  QLEN  signed sample x[i].
- `in_h`  in  QLEN  signed kernel tap h[i].
- `out_valid`  out  1  `out_y` holds y[k].
- `out_ready`  in  1  consumer accepts `out_y`.
- `out_y`  out  QLEN  signed saturated result y[k].
- `out_last`  out  1  high with `out_valid` when k = N−1.

## Operation
- The block has two register files, X[0..N−1] and H[0..N−1], each QLEN bits wide.
- Index counters `i`, `k` and `j` are each $clog2(N) bits wide and wrap naturally.
- The accumulator `acc` is signed, ACC_W = QLEN + $clog2(N) bits.
- FSM states: LOAD, MAC, OUT.
- **LOAD**
  - `in_ready` = 1. On each handshake (`in_valid` && `in_ready`), write X[i] ← `in_x` and H[i] ← `in_h`, then increment `i`.
  - When the handshake with i = N−1 occurs, go to MAC with k = 0, j = 0 and `acc` = 0.
- **MAC**
  - One product per cycle: `fxp_mult`(X[j], H[(k−j) mod N]). The index k−j is computed in $clog2(N) bits, so modular wrap is free.
  - `acc` ← `acc` + sign-extended product. The product is the `fxp_mult` result: bits [QLEN+FRAC_SIZE−1 : FRAC_SIZE] of the full 2·QLEN product. Any wrap inside the multiplier is accepted as-is.
  - `j` increments each cycle. The step with j = N−1 moves the FSM to OUT with the final sum registered.
- **OUT**
  - `out_valid` = 1. `out_y` = `acc` saturated to [−2^(QLEN−1), 2^(QLEN−1)−1]. `out_last` = (k == N−1).
  - On handshake with k < N−1: k++, j = 0, `acc` = 0, go to MAC.
  - On handshake with k = N−1: go to LOAD with i = 0.
- `in_ready` = 0 in MAC and OUT. `out_valid` = 0 in LOAD and MAC.
- X and H are not cleared between frames; the next frame overwrites every entry.
- **Reset**, asynchronous, at any time including mid-MAC or mid-OUT:
  - state ← LOAD; `i`, `k`, `j` ← 0; `acc` ← 0. The partial frame is discarded.
  - Output reset values: `out_valid` = 0, `out_last` = 0, `out_y` = 0, `in_ready` = 1.
  - No handshake is taken while `rst` is high.

## Timing
- Input: one pair per cycle at full rate. Loading a frame takes N handshakes.
- If the last input handshake occurs in cycle t, MAC runs in cycles t+1..t+N and `out_valid` rises in t+N+1.
- Per output: N MAC cycles plus ≥1 OUT cycle. With `out_ready` held high, outputs are spaced N+1 cycles apart.
- After the final output handshake in cycle u, `in_ready` = 1 in u+1.
- Backpressure: while `out_valid` && !`out_ready`, `out_y` and `out_last` hold stable. `out_valid` never drops without a handshake, except on reset.
- Frame throughput: N + N·(N+1) cycles minimum. There is no overlap of load and compute.

## Structure
- Package `circ_conv_pkg` holds:
  - the `typedef enum logic [1:0] {LOAD, MAC, OUT} state_t`;
  - a function `acc_w(QLEN, N)`;
  - a function `sat(acc)` that maps the ACC_W-bit accumulator to QLEN bits.
- Exactly one `fxp_mult` sub-module instance (QLEN, FRAC_SIZE passed through), fed combinationally from the X/H read muxes.
- Control is a single FSM plus counters; no further sub-modules.

## Test plan
- **Impulse:** N=8, x = [0x1000, 0, …, 0], h = [0x1000, 0x2000, …, 0x8000 pattern]. Expect y[k] = h[k] for all k and `out_last` only on y[7].
- **Wrap-around:** x = delta at index 1 (0x1000). Expect y[0] = h[7] and y[k] = h[k−1] for k ≥ 1.
- **Saturation:**
  - All x = 0x7000 (7.0) and all h = 0x1000 (1.0): the sum is 56.0, so every y = 0x7FFF.
  - All x = 0x9000 (−7.0): every y = 0x8000.
- **Backpressure:** hold `out_ready` low for 5 cycles at y[3]. `out_y` and `out_last` stay stable, `out_valid` stays 1, `in_ready` stays 0, and no output is lost or duplicated.
- **Reset mid-MAC:** pulse `rst` during k=2, j=4.
  - Immediately: `out_valid` = 0 and the FSM is in LOAD with `in_ready` = 1.
  - A following impulse frame then yields exactly h with no residue.
- **Back-to-back frames:** hold `in_valid` and `out_ready` high continuously. Expect the latency counts from Timing exactly and correct results for both frames.
